// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified main-memory arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin winner selection).
package mem_arb_pkg;

  localparam int unsigned DEF_LINE_W  = 64;
  localparam int unsigned DEF_LADDR_W = 14;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Requester identity
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I-side and D-side miss engines.
// ARB_ROUND_ROBIN_EN: contention goes to the requester that did not win last;
// otherwise D always beats I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e i_last_owner,
`endif
  output logic   o_grant_valid_c,
  output owner_e o_grant_owner_c
);

  // Pick a winner; only meaningful while o_grant_valid_c is high
  always_comb begin
    o_grant_valid_c = i_ireq | i_dreq;
    o_grant_owner_c = OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_ireq && i_dreq) begin
      o_grant_owner_c = (i_last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (i_dreq) begin
      o_grant_owner_c = OWN_D;
    end
`else
    if (i_dreq) begin
      o_grant_owner_c = OWN_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequencer/arbiter for the main-memory port shared by the I- and D-caches.
// Grants one requester, holds m_re/m_we for MEM_LAT cycles, then pulses done.
// Optional feature macro: ARB_ROUND_ROBIN_EN (adds the last-owner flop).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned LINE_W  = DEF_LINE_W,
  parameter int unsigned LADDR_W = DEF_LADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  input  logic [LADDR_W-1:0] i_addr,
  output logic               i_done,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [LADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic               d_done,
  output logic [LINE_W-1:0]  rdata,
  output logic [LADDR_W-1:0] m_addr,
  output logic               m_re,
  output logic               m_we,
  output logic [LINE_W-1:0]  m_wdata,
  input  logic [LINE_W-1:0]  m_rdata,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  logic [1:0]         r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  owner_e             r_owner, w_owner;
  logic               r_we, w_we;
  logic [LADDR_W-1:0] r_addr, w_addr;
  logic [LINE_W-1:0]  r_wdata, w_wdata;
  logic [LINE_W-1:0]  r_rdata, w_rdata;
  logic               r_i_done, w_i_done;
  logic               r_d_done, w_d_done;
  logic               r_m_re, w_m_re;
  logic               r_m_we, w_m_we;
  logic               r_busy, w_busy;
  logic               w_grant_valid;
  owner_e             w_grant_owner;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e             r_last_owner, w_last_owner;
`endif

  mem_arb_pick u_pick (
    .i_ireq          (i_req),
    .i_dreq          (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_owner    (r_last_owner),
`endif
    .o_grant_valid_c (w_grant_valid),
    .o_grant_owner_c (w_grant_owner)
  );

  // Next-state and next-output decode; requests only matter in IDLE
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_owner  = r_owner;
    w_we     = r_we;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdata  = r_rdata;
    w_i_done = 1'b0;
    w_d_done = 1'b0;
    w_m_re   = r_m_re;
    w_m_we   = r_m_we;
    w_busy   = r_busy;
`ifdef ARB_ROUND_ROBIN_EN
    w_last_owner = r_last_owner;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state = ST_ACC;
          w_cnt   = '0;
          w_owner = w_grant_owner;
          if (w_grant_owner == OWN_D) begin
            w_we    = d_we;
            w_addr  = d_addr;
            w_wdata = d_wdata;
          end else begin
            w_we    = 1'b0;
            w_addr  = i_addr;
            w_wdata = '0;
          end
          w_m_re = ~w_we;
          w_m_we = w_we;
          w_busy = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          w_last_owner = w_grant_owner;
`endif
        end
      end
      ST_ACC: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
          w_state  = ST_RESP;
          w_m_re   = 1'b0;
          w_m_we   = 1'b0;
          w_i_done = (r_owner == OWN_I);
          w_d_done = (r_owner == OWN_D);
          if (!r_we) begin
            w_rdata = m_rdata;
          end
        end
      end
      ST_RESP: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
        w_m_re  = 1'b0;
        w_m_we  = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State, latches and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_owner  <= OWN_I;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_m_re   <= 1'b0;
      r_m_we   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_owner <= OWN_I;
`endif
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_owner  <= w_owner;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdata  <= w_rdata;
      r_i_done <= w_i_done;
      r_d_done <= w_d_done;
      r_m_re   <= w_m_re;
      r_m_we   <= w_m_we;
      r_busy   <= w_busy;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_owner <= w_last_owner;
`endif
    end
  end

  assign i_done  = r_i_done;
  assign d_done  = r_d_done;
  assign rdata   = r_rdata;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign m_re    = r_m_re;
  assign m_we    = r_m_we;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table + scoreboard with a memory model,
// plus hand sequences for input changes, reset abort and MEM_LAT=1.
module tb_mem_arbiter;

  localparam int unsigned LAT = 4;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [13:0] iaddr;
    logic [13:0] daddr;
    logic [63:0] wdata;
    logic        first_d;
  } vec_t;

  typedef struct {
    logic        own_d;
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [13:0] i_addr = '0, d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        i_done, d_done, m_re, m_we, busy;
  logic [63:0] rdata, m_wdata;
  logic [63:0] m_rdata = '0;
  logic [13:0] m_addr;

  logic        l1_i_req = 1'b0;
  logic        l1_i_done, l1_d_done, l1_m_re, l1_m_we, l1_busy;
  logic [63:0] l1_rdata, l1_m_wdata, l1_m_rdata;
  logic [13:0] l1_m_addr;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [63:0] mem_store [0:16383];
  logic [63:0] ref_store [0:16383];
  logic [63:0] ref_last = '0;
  sb_t         sb_q [$];
  int          starts [$];
  vec_t        vecs [7];

  mem_arbiter #(.MEM_LAT(LAT), .LINE_W(64), .LADDR_W(14)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(1), .LINE_W(64), .LADDR_W(14)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(l1_i_req), .i_addr(14'h0042), .i_done(l1_i_done),
    .d_req(1'b0), .d_we(1'b0), .d_addr(14'h0000), .d_wdata(64'h0), .d_done(l1_d_done),
    .rdata(l1_rdata), .m_addr(l1_m_addr), .m_re(l1_m_re), .m_we(l1_m_we),
    .m_wdata(l1_m_wdata), .m_rdata(l1_m_rdata), .busy(l1_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign l1_m_rdata = l1_m_re ? 64'hCAFE_F00D_1234_5678 : 64'h0;

  // Memory returns data on the negedge so it is stable at the sampling edge
  always @(negedge clk) m_rdata <= m_re ? mem_store[m_addr] : 64'h0;

  function automatic logic [63:0] dflt(input logic [13:0] a);
    return {a, 2'b10, ~a, 2'b01, a, 2'b11, ~a, 2'b00};
  endfunction

  // Backing memory contents and write port
  initial begin
    for (int i = 0; i < 16384; i++) mem_store[i] = dflt(14'(i));
    mem_store[14'h0123] = 64'hDEAD_BEEF_0000_1111;
    forever begin
      @(posedge clk);
      if (m_we) mem_store[m_addr] = m_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Scoreboard monitor: checks each access window and each done pulse
  initial begin : monitor
    logic prev_busy;
    int   start_c;
    int   acc_n;
    logic bad;
    sb_t  e;
    prev_busy = 1'b0; start_c = 0; acc_n = 0; bad = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0; acc_n = 0; bad = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          start_c = cyc; acc_n = 0; bad = 1'b0;
          starts.push_back(cyc);
        end
        if (m_re || m_we) begin
          acc_n++;
          if (sb_q.size() == 0) bad = 1'b1;
          else if (m_addr != sb_q[0].addr || m_we != sb_q[0].we || m_re == sb_q[0].we ||
                   (sb_q[0].we && m_wdata != sb_q[0].wdata)) bad = 1'b1;
        end
        if (i_done || d_done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'({d_done, i_done}), 64'h0);
          end else begin
            e = sb_q.pop_front();
            chk("done_owner", 64'({d_done, i_done}), e.own_d ? 64'h2 : 64'h1);
            chk("rdata", rdata, e.rdata);
            chk("latency", 64'(cyc - start_c), 64'(LAT));
            chk("access_cycles", 64'(acc_n), 64'(LAT));
            chk("access_lines", 64'(bad), 64'h0);
          end
        end
        prev_busy = busy;
      end
    end
  end

  task automatic push_txn(input logic own_d, input logic we, input logic [13:0] a,
                          input logic [63:0] wd);
    sb_t e;
    e.own_d = own_d; e.we = we; e.addr = a; e.wdata = wd;
    if (we) begin
      ref_store[a] = wd;
      e.rdata = ref_last;
    end else begin
      e.rdata = ref_store[a];
      ref_last = e.rdata;
    end
    sb_q.push_back(e);
  endtask

  // Requesters drop req on their done pulse; stop once idle with nothing pending
  task automatic serve(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (!i_req && !d_req && !busy) break;
      n++;
    end
    chk("serve_in_budget", 64'(n < budget), 64'h1);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.dreq && (!v.ireq || v.first_d)) begin
      push_txn(1'b1, v.dwe, v.daddr, v.wdata);
      if (v.ireq) push_txn(1'b0, 1'b0, v.iaddr, 64'h0);
    end else begin
      if (v.ireq) push_txn(1'b0, 1'b0, v.iaddr, 64'h0);
      if (v.dreq) push_txn(1'b1, v.dwe, v.daddr, v.wdata);
    end
    starts.delete();
    i_req = v.ireq; d_req = v.dreq; d_we = v.dwe;
    i_addr = v.iaddr; d_addr = v.daddr; d_wdata = v.wdata;
    serve(40);
    if (v.ireq && v.dreq) begin
      chk("start_spacing", 64'((starts.size() == 2) ? starts[1] - starts[0] : -1),
          64'(LAT + 2));
    end
    d_we = 1'b0;
  endtask

  initial begin : main
    vec_t v;
    int   seen;
    for (int i = 0; i < 16384; i++) ref_store[i] = dflt(14'(i));
    ref_store[14'h0123] = 64'hDEAD_BEEF_0000_1111;

    //          ireq  dreq  dwe   iaddr     daddr     wdata                   first_d
    vecs[0] = '{1'b1, 1'b0, 1'b0, 14'h0123, 14'h0000, 64'h0,                  1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 14'h0000, 14'h3FFF, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 14'h0000, 14'h3FFF, 64'h0,                  1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 14'h3FFF, 14'h0000, 64'h0,                  1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 14'h0010, 14'h0010, 64'h0123_4567_89AB_CDEF, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 14'h0000, 14'h0000, 64'h0,                  1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 14'h0000, 14'h1555, 64'h0,                  1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({i_done, d_done, m_re, m_we, busy}), 64'h0);
    chk("rst_m_addr", 64'(m_addr), 64'h0);
    chk("rst_m_wdata", m_wdata, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'h0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // D-side inputs change mid-access: latched address/direction must hold
    push_txn(1'b1, 1'b0, 14'h0200, 64'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0200;
    repeat (2) @(negedge clk);
    d_addr = 14'h0300; d_we = 1'b1; d_wdata = 64'hFFFF_0000_FFFF_0000;
    serve(40);
    d_we = 1'b0;

    // Reset in ACC cycle 2 aborts silently
    push_txn(1'b0, 1'b0, 14'h0123, 64'h0);
    i_req = 1'b1; i_addr = 14'h0123;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 64'({i_done, d_done, m_re, m_we, busy}), 64'h0);
    chk("abort_m_addr", 64'(m_addr), 64'h0);
    chk("abort_rdata", rdata, 64'h0);
    sb_q.delete();
    ref_last = 64'h0;
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_done || d_done || busy) seen++;
    end
    chk("no_done_after_abort", 64'(seen), 64'h0);
    v = '{1'b1, 1'b0, 1'b0, 14'h0123, 14'h0000, 64'h0, 1'b0};
    run_vec(v);

    // D alone, then a simultaneous pair: fixed priority repeats D, round-robin gives I
    v = '{1'b0, 1'b1, 1'b0, 14'h0000, 14'h0005, 64'h0, 1'b1};
    run_vec(v);
    v = '{1'b1, 1'b1, 1'b0, 14'h0006, 14'h0007, 64'h0, !RR};
    run_vec(v);

    // MEM_LAT=1 instance: one access cycle, done in cycle 2
    l1_i_req = 1'b1;
    @(negedge clk);
    chk("l1_acc", 64'({l1_m_re, l1_m_we, l1_busy, l1_i_done}), 64'b1010);
    chk("l1_m_addr", 64'(l1_m_addr), 64'h0042);
    @(negedge clk);
    chk("l1_done", 64'({l1_m_re, l1_i_done, l1_d_done}), 64'b010);
    chk("l1_rdata", l1_rdata, 64'hCAFE_F00D_1234_5678);
    l1_i_req = 1'b0;
    @(negedge clk);
    chk("l1_idle", 64'({l1_busy, l1_i_done}), 64'h0);
    chk("l1_m_wdata", l1_m_wdata, 64'h0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
